// File: rtl/slc3_pkg.sv
// slc3_pkg: shared encodings for the SLC-3 control unit (states, opcodes, ALU and mux codes).
package slc3_pkg;
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_PSE = 4'b1101;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_NOT  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b111;
    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_BUS  = 2'b01;
    localparam logic [1:0] PC_ADDR = 2'b10;
    localparam logic [1:0] A2_ZERO = 2'b00;
    localparam logic [1:0] A2_OFF6 = 2'b01;
    localparam logic [1:0] A2_OFF9 = 2'b10;
    localparam logic [4:0] S_HALTED = 5'd0;
    localparam logic [4:0] S_18     = 5'd1;
    localparam logic [4:0] S_33_1   = 5'd2;
    localparam logic [4:0] S_33_2   = 5'd3;
    localparam logic [4:0] S_33_3   = 5'd4;
    localparam logic [4:0] S_35     = 5'd5;
    localparam logic [4:0] S_32     = 5'd6;
    localparam logic [4:0] S_01     = 5'd7;
    localparam logic [4:0] S_05     = 5'd8;
    localparam logic [4:0] S_09     = 5'd9;
    localparam logic [4:0] S_00     = 5'd10;
    localparam logic [4:0] S_22     = 5'd11;
    localparam logic [4:0] S_12     = 5'd12;
    localparam logic [4:0] S_06     = 5'd13;
    localparam logic [4:0] S_25_1   = 5'd14;
    localparam logic [4:0] S_25_2   = 5'd15;
    localparam logic [4:0] S_25_3   = 5'd16;
    localparam logic [4:0] S_27     = 5'd17;
    localparam logic [4:0] S_07     = 5'd18;
    localparam logic [4:0] S_23     = 5'd19;
    localparam logic [4:0] S_16_1   = 5'd20;
    localparam logic [4:0] S_16_2   = 5'd21;
    localparam logic [4:0] S_PAUSE1 = 5'd22;
    localparam logic [4:0] S_PAUSE2 = 5'd23;
endpackage

// File: rtl/slc3_control_unit.sv
// slc3_control_unit: Moore sequencer stepping fetch/decode/execute for the reduced LC-3 subset.
module slc3_control_unit
    import slc3_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [2:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);
    logic [4:0] state, next_state;

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) state <= S_HALTED;
        else       state <= next_state;

    always_comb begin
        next_state = S_HALTED;
        case (state)
            S_HALTED: next_state = Run ? S_18 : S_HALTED;
            S_18:     next_state = S_33_1;
            S_33_1:   next_state = S_33_2;
            S_33_2:   next_state = S_33_3;
            S_33_3:   next_state = S_35;
            S_35:     next_state = S_32;
            S_32:
                case (Opcode)
                    OP_ADD:  next_state = S_01;
                    OP_AND:  next_state = S_05;
                    OP_NOT:  next_state = S_09;
                    OP_BR:   next_state = S_00;
                    OP_JMP:  next_state = S_12;
                    OP_LDR:  next_state = S_06;
                    OP_STR:  next_state = S_07;
                    OP_PSE:  next_state = S_PAUSE1;
                    default: next_state = S_18;
                endcase
            S_00:     next_state = BEN ? S_22 : S_18;
            S_06:     next_state = S_25_1;
            S_25_1:   next_state = S_25_2;
            S_25_2:   next_state = S_25_3;
            S_25_3:   next_state = S_27;
            S_07:     next_state = S_23;
            S_23:     next_state = S_16_1;
            S_16_1:   next_state = S_16_2;
            S_PAUSE1: next_state = Continue ? S_PAUSE2 : S_PAUSE1;
            S_PAUSE2: next_state = Continue ? S_PAUSE2 : S_18;
            default:  next_state = S_18;
        endcase
    end

    always_comb begin
        LD_MAR = 1'b0;
        LD_MDR = 1'b0;
        LD_IR = 1'b0;
        LD_BEN = 1'b0;
        LD_CC = 1'b0;
        LD_REG = 1'b0;
        LD_PC = 1'b0;
        GatePC = 1'b0;
        GateMDR = 1'b0;
        GateALU = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX = PC_INC;
        DRMUX = 1'b0;
        SR1MUX = 1'b0;
        SR2MUX = 1'b0;
        ADDR1MUX = 1'b0;
        ADDR2MUX = A2_ZERO;
        ALUK = ALU_PASS;
        Mem_OE = 1'b1;
        Mem_WE = 1'b1;
        case (state)
            S_18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC = 1'b1;
            end
            S_33_1, S_33_2, S_25_1, S_25_2: Mem_OE = 1'b0;
            S_33_3, S_25_3: begin
                Mem_OE = 1'b0;
                LD_MDR = 1'b1;
            end
            S_35: begin
                GateMDR = 1'b1;
                LD_IR = 1'b1;
            end
            S_32: LD_BEN = 1'b1;
            S_01, S_05, S_09: begin
                ALUK = (state == S_01) ? ALU_ADD : (state == S_05) ? ALU_AND : ALU_NOT;
                SR1MUX = 1'b1;
                SR2MUX = IR_5;
                GateALU = 1'b1;
                LD_REG = 1'b1;
                LD_CC = 1'b1;
            end
            S_22: begin
                ADDR2MUX = A2_OFF9;
                PCMUX = PC_ADDR;
                LD_PC = 1'b1;
            end
            S_12: begin
                SR1MUX = 1'b1;
                GateALU = 1'b1;
                PCMUX = PC_BUS;
                LD_PC = 1'b1;
            end
            S_06, S_07: begin
                SR1MUX = 1'b1;
                ADDR1MUX = 1'b1;
                ADDR2MUX = A2_OFF6;
                GateMARMUX = 1'b1;
                LD_MAR = 1'b1;
            end
            S_27: begin
                GateMDR = 1'b1;
                LD_REG = 1'b1;
                LD_CC = 1'b1;
            end
            S_23: begin
                GateALU = 1'b1;
                LD_MDR = 1'b1;
            end
            S_16_1, S_16_2: Mem_WE = 1'b0;
            default: ;
        endcase
    end
endmodule

// File: doc/slc3_control_unit.md
# slc3_control_unit

Moore-style instruction sequencer for the SLC-3 datapath. It is the control-side counterpart of the datapath ALU: it decodes the fetched opcode and drives ALUK, register/bus load enables, gate and mux selects, and the memory strobes. It sits between the instruction register and every datapath load/gate point, and steps fetch → decode → execute for a reduced LC-3 instruction subset.

## Interface
Parameters:
- none (encodings live in the shared package)

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; forces state Halted
- Run  in  1  start execution from Halted (level)
- Continue  in  1  resume from PAUSE (level)
- Opcode  in  4  IR[15:12]
- IR_5  in  1  operate immediate select (IR[5])
- BEN  in  1  branch-enable flag from datapath
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  out  1 each  register load enables
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high per cycle
- PCMUX  out  2  00 PC+1, 01 bus, 10 address adder
- DRMUX  out  1  0 IR[11:9], 1 R7
- SR1MUX  out  1  0 IR[11:9], 1 IR[8:6]
- SR2MUX  out  1  0 register IR[2:0], 1 sext(IR[4:0]); equals IR_5 in operate states
- ADDR1MUX  out  1  0 PC, 1 SR1
- ADDR2MUX  out  2  00 zero, 01 sext off6, 10 sext off9, 11 sext off11
- ALUK  out  3  000 ADD, 010 AND, 101 NOT, 111 pass A (matches ALU function codes)
- Mem_OE, Mem_WE  out  1 each  active-low memory strobes

## Operation
- Outputs are a pure function of the current state. The default in every state is: all loads/gates 0, muxes 0, ALUK 111, Mem_OE/Mem_WE 1.
- Reset value of every output is the Halted defaults.
- States and transitions:
  - Halted: Run=1 → S_18, else stay.
  - S_18: GatePC, LD_MAR, PCMUX=00, LD_PC → S_33_1.
  - S_33_1, S_33_2: Mem_OE=0 → next.
  - S_33_3: Mem_OE=0, LD_MDR → S_35.
  - S_35: GateMDR, LD_IR → S_32.
  - S_32: LD_BEN; decode on Opcode:
    - 0001 → S_01; 0101 → S_05; 1001 → S_09; 0000 → S_00; 1100 → S_12; 0110 → S_06; 0111 → S_07; 1101 → PauseIR1.
    - Any other opcode → S_18 (treated as a no-op).
  - S_01 / S_05 / S_09: ALUK = ADD / AND / NOT, SR1MUX=1, SR2MUX=IR_5, GateALU, LD_REG, LD_CC, DRMUX=0 → S_18.
  - S_00: BEN=1 → S_22, else S_18.
  - S_22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC → S_18.
  - S_12: SR1MUX=1, ALUK=111, GateALU, PCMUX=01, LD_PC → S_18.
  - S_06 (LDR): SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR → S_25_1.
  - S_25_1, S_25_2, S_25_3: same as S_33_x → S_27.
  - S_27: GateMDR, LD_REG, LD_CC, DRMUX=0 → S_18.
  - S_07 (STR): address as S_06 → S_23.
  - S_23: SR1MUX=0, ALUK=111, GateALU, LD_MDR → S_16_1.
  - S_16_1, S_16_2: Mem_WE=0 → next; S_16_2 → S_18.
  - PauseIR1: Continue=0 stay, else PauseIR2.
  - PauseIR2: Continue=1 stay, else S_18.
- Reset asserted mid-instruction, including mid-write: state → Halted immediately and Mem_WE returns to 1 the same cycle. No partial-state recovery.
- Run deasserted outside Halted is ignored; the machine never returns to Halted except by Reset.

## Timing
- One state per clock.
- Fetch is 6 cycles (S_18 … S_32).
- ADD/AND/NOT/JMP/BR-not-taken: 7 cycles total; BR taken: 8; STR: 10; LDR: 11.
- Memory read data must be valid by the end of the 3rd Mem_OE cycle. Write holds Mem_WE low for exactly 2 cycles with MAR/MDR stable.
- PAUSE requires a full Continue high→low handshake; a Continue already high on entry advances to PauseIR2 on the next edge.

## Structure
- Shared package slc3_pkg: state enum, opcode localparams, ALUK codes (ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS), PCMUX/ADDR2MUX encodings.
- Single module, no sub-module: one always_ff state register with async reset, one always_comb next-state, one always_comb output decode.

## Test plan
- Reset=1 with Run=1 → state Halted, Mem_OE=Mem_WE=1, ALUK=111, all loads 0; release Reset, Run=1 → S_18 next edge.
- Opcode 0001, IR_5=1 after fetch → cycle 7: ALUK=000, SR2MUX=1, GateALU=LD_REG=LD_CC=1; cycle 8 back in S_18.
- Opcode 1001 then 0101 with IR_5=0 → ALUK 101 then 010, SR2MUX=0.
- Opcode 0000: BEN=0 → S_18 after S_00; BEN=1 → S_22 with PCMUX=10, ADDR2MUX=10, LD_PC=1.
- Opcode 0111 → Mem_WE low exactly 2 consecutive cycles. Reset pulsed during S_16_1 → Mem_WE=1 asynchronously, state Halted.
- Opcode 1101, Continue held 0 for 5 cycles → stays PauseIR1; Continue 1 → PauseIR2; Continue 0 → S_18. Undefined opcode 1111 → S_18 directly after S_32.
